// File: rtl/pwm_capture.sv
`timescale 1ns/1ps
// Recovers direction and 8-bit speed from a pair of motor PWM lines by counting
// high cycles over one PWM period and reporting only debounced, repeated results.
module pwm_capture #(
    parameter int PERIOD   = 256,
    parameter int CNT_W    = 9,
    parameter int STABLE_N = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       pwm_in1,
    input  logic       pwm_in2,
    output logic [7:0] speed,
    output logic [1:0] dir,
    output logic       meas_valid,
    output logic       changed
);

    typedef enum logic {TRACK, LOCKED} state_t;

    logic [1:0]       pwm_raw;
    logic [1:0]       sync1_reg;
    logic [1:0]       sync2_reg;
    logic [CNT_W-1:0] win_cnt_reg;
    logic             win_end;
    logic [CNT_W-1:0] hi_reg [2];
    logic [CNT_W-1:0] h      [2];
    logic [1:0]       active;

    logic [1:0] cand_dir;
    logic [7:0] cand_speed;
    logic [9:0] cand;
    logic [9:0] rep;

    state_t     state_reg,  state_next;
    logic [3:0] stable_reg, stable_next;
    logic [9:0] prev_reg,   prev_next;
    logic [1:0] dir_reg,    dir_next;
    logic [7:0] speed_reg,  speed_next;
    logic       mv_reg,     mv_next;
    logic       ch_reg,     ch_next;

    function automatic logic [7:0] sat255(input logic [CNT_W-1:0] x);
        if (32'(x) >= 32'd255)
            return 8'hFF;
        else
            return 8'(x);
    endfunction

    assign pwm_raw = {pwm_in2, pwm_in1};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= pwm_raw;
            sync2_reg <= sync1_reg;
        end
    end

    assign win_end = (win_cnt_reg == CNT_W'(PERIOD - 1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            win_cnt_reg <= '0;
        else if (win_end)
            win_cnt_reg <= '0;
        else
            win_cnt_reg <= win_cnt_reg + CNT_W'(1);
    end

    // h includes the current cycle, so at the window end it is the complete count
    // and the register can simply restart from zero.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_line
            assign h[gi]      = hi_reg[gi] + CNT_W'(sync2_reg[gi]);
            assign active[gi] = (h[gi] != '0);

            always_ff @(posedge CLK or posedge RST) begin
                if (RST)
                    hi_reg[gi] <= '0;
                else if (win_end)
                    hi_reg[gi] <= '0;
                else
                    hi_reg[gi] <= h[gi];
            end
        end
    endgenerate

    always_comb begin
        cand_dir   = active;
        cand_speed = 8'd0;
        case (active)
            2'b01:   cand_speed = sat255(h[0]);
            2'b10:   cand_speed = sat255(h[1]);
            default: cand_speed = 8'd0;
        endcase
    end

    assign cand = {cand_dir, cand_speed};
    assign rep  = {dir_reg, speed_reg};

    always_comb begin
        state_next  = state_reg;
        stable_next = stable_reg;
        prev_next   = prev_reg;
        dir_next    = dir_reg;
        speed_next  = speed_reg;
        mv_next     = win_end;
        ch_next     = 1'b0;
        if (win_end) begin
            if (cand == prev_reg) begin
                if (stable_reg >= 4'(STABLE_N))
                    stable_next = 4'(STABLE_N);
                else
                    stable_next = stable_reg + 4'd1;
            end else begin
                stable_next = 4'd1;
                prev_next   = cand;
            end
            // A locked value that keeps being confirmed needs no further action.
            if (!(state_reg == LOCKED && cand == rep)) begin
                if (stable_next == 4'(STABLE_N)) begin
                    state_next = LOCKED;
                    if (cand != rep) begin
                        dir_next   = cand_dir;
                        speed_next = cand_speed;
                        ch_next    = 1'b1;
                    end
                end else begin
                    state_next = TRACK;
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg  <= TRACK;
            stable_reg <= '0;
            prev_reg   <= '0;
            dir_reg    <= '0;
            speed_reg  <= '0;
            mv_reg     <= 1'b0;
            ch_reg     <= 1'b0;
        end else begin
            state_reg  <= state_next;
            stable_reg <= stable_next;
            prev_reg   <= prev_next;
            dir_reg    <= dir_next;
            speed_reg  <= speed_next;
            mv_reg     <= mv_next;
            ch_reg     <= ch_next;
        end
    end

    assign speed      = speed_reg;
    assign dir        = dir_reg;
    assign meas_valid = mv_reg;
    assign changed    = ch_reg;

endmodule

// File: tb/tb_pwm_capture.sv
`timescale 1ns/1ps
// Randomized bench for pwm_capture: a window-sum reference model predicts every
// output on every cycle, plus fixed expectations at the end of each scenario.
module tb_pwm_capture;
    localparam int PERIOD   = 256;
    localparam int CNT_W    = 9;
    localparam int STABLE_N = 2;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       pwm_in1 = 1'b0;
    logic       pwm_in2 = 1'b0;
    logic [7:0] speed;
    logic [1:0] dir;
    logic       meas_valid;
    logic       changed;

    pwm_capture #(.PERIOD(PERIOD), .CNT_W(CNT_W), .STABLE_N(STABLE_N)) dut (
        .CLK(CLK), .RST(RST), .pwm_in1(pwm_in1), .pwm_in2(pwm_in2),
        .speed(speed), .dir(dir), .meas_valid(meas_valid), .changed(changed)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Stimulus waveform description
    int hi1 = 0, hi2 = 0, ph1 = 0, ph2 = 0;
    int tcnt = 0;
    bit alt = 0;

    // Reference model state
    bit         q1[$];
    bit         q2[$];
    int         acc1, acc2, wpos;
    logic [9:0] cands[$];
    logic [1:0] e_dir;
    logic [7:0] e_speed;
    bit         e_mv, e_ch;

    function automatic bit line_val(input int hi, input int ph, input int t);
        return ((t + ph) % PERIOD) < hi;
    endfunction

    function automatic logic [7:0] sat(input int x);
        return (x >= 255) ? 8'd255 : 8'(x);
    endfunction

    task automatic model_clear();
        q1.delete(); q2.delete(); cands.delete();
        acc1 = 0; acc2 = 0; wpos = 0;
        e_dir = 2'b00; e_speed = 8'd0; e_mv = 0; e_ch = 0;
    endtask

    // Each window's candidate comes from the plain sum of the line values seen
    // two edges earlier; outputs follow once the last STABLE_N candidates agree.
    task automatic model_edge(input bit p1, input bit p2);
        bit u1, u2, same;
        logic [1:0] cd;
        logic [7:0] sp;
        logic [9:0] c;
        q1.push_back(p1); q2.push_back(p2);
        u1 = (q1.size() >= 3) ? q1[q1.size()-3] : 1'b0;
        u2 = (q2.size() >= 3) ? q2[q2.size()-3] : 1'b0;
        if (q1.size() > 3) begin void'(q1.pop_front()); void'(q2.pop_front()); end
        acc1 += int'(u1); acc2 += int'(u2); wpos++;
        e_mv = 0; e_ch = 0;
        if (wpos == PERIOD) begin
            cd = {acc2 != 0, acc1 != 0};
            sp = (cd == 2'b01) ? sat(acc1) : (cd == 2'b10) ? sat(acc2) : 8'd0;
            c = {cd, sp};
            cands.push_back(c);
            e_mv = 1;
            same = (cands.size() >= STABLE_N);
            for (int i = 1; i <= STABLE_N && same; i++)
                if (cands[cands.size()-i] != c) same = 0;
            if (same && c != {e_dir, e_speed}) begin
                e_dir = cd; e_speed = sp; e_ch = 1;
            end
            acc1 = 0; acc2 = 0; wpos = 0;
        end
    endtask

    // Called at a falling edge; drives lines, advances one clock, checks outputs.
    task automatic cycle();
        if (alt) hi1 = (cands.size() % 2 == 0) ? 100 : 120;
        pwm_in1 = line_val(hi1, ph1, tcnt);
        pwm_in2 = line_val(hi2, ph2, tcnt);
        tcnt++;
        @(posedge CLK);
        model_edge(pwm_in1, pwm_in2);
        #1;
        chk("meas_valid", 32'(meas_valid), 32'(e_mv));
        chk("changed",    32'(changed),    32'(e_ch));
        chk("dir",        32'(dir),        32'(e_dir));
        chk("speed",      32'(speed),      32'(e_speed));
        @(negedge CLK);
    endtask

    task automatic run_windows(input int n);
        for (int i = 0; i < n * PERIOD; i++) cycle();
    endtask

    task automatic do_reset();
        #2 RST = 1'b1;
        #1;
        chk("rst_speed",      32'(speed),      32'd0);
        chk("rst_dir",        32'(dir),        32'd0);
        chk("rst_meas_valid", 32'(meas_valid), 32'd0);
        chk("rst_changed",    32'(changed),    32'd0);
        @(negedge CLK);
        @(negedge CLK);
        model_clear();
        RST = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [1:0] d, input logic [7:0] s);
        chk({tag, "_dir"},   32'(dir),   32'(d));
        chk({tag, "_speed"}, 32'(speed), 32'(s));
    endtask

    initial begin
        int nseg;
        model_clear();
        @(negedge CLK);
        do_reset();

        // Idle lines
        run_windows(3);
        expect_out("idle", 2'b00, 8'd0);

        // Direction 1 at 100/256, random phase and start offset
        ph1 = $urandom_range(0, PERIOD - 1);
        for (int i = 0; i < int'($urandom_range(0, PERIOD - 1)); i++) cycle();
        hi1 = 100;
        run_windows(4);
        expect_out("dir1_100", 2'b01, 8'd100);

        // Switch to direction 2 at 200/256
        hi1 = 0; hi2 = 200; ph2 = $urandom_range(0, PERIOD - 1);
        run_windows(4);
        expect_out("dir2_200", 2'b10, 8'd200);

        // Line 1 stuck high
        hi2 = 0; hi1 = PERIOD;
        run_windows(3);
        expect_out("stuck_high", 2'b01, 8'd255);

        // Both lines at 50%
        hi1 = 128; hi2 = 128;
        ph1 = $urandom_range(0, PERIOD - 1); ph2 = $urandom_range(0, PERIOD - 1);
        run_windows(3);
        expect_out("both_fault", 2'b11, 8'd0);

        // Lock at 100, then alternate candidates every window
        hi2 = 0; hi1 = 100; ph1 = 0;
        run_windows(3);
        expect_out("pre_alt", 2'b01, 8'd100);
        alt = 1;
        run_windows(6);
        alt = 0;
        expect_out("alternate", 2'b01, 8'd100);

        // Random duty segments
        nseg = 5;
        for (int s = 0; s < nseg; s++) begin
            hi1 = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, PERIOD));
            hi2 = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, PERIOD)) : 0;
            ph1 = $urandom_range(0, PERIOD - 1); ph2 = $urandom_range(0, PERIOD - 1);
            run_windows(int'($urandom_range(2, 4)));
        end

        // Reset mid-window while locked at direction 1 / 100
        hi1 = 100; hi2 = 0;
        run_windows(4);
        expect_out("pre_reset", 2'b01, 8'd100);
        for (int i = 0; i < int'($urandom_range(10, PERIOD - 10)); i++) cycle();
        do_reset();
        run_windows(4);
        expect_out("relock", 2'b01, 8'd100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
